ex_muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide unit in the execute stage.
- Consumes forwarded operands, the destination register and the M-extension funct3 from the decode/execute pipeline register.
- Holds busy while it computes; the hazard unit uses busy to stall fetch, decode and execute.
- Returns a one-cycle done/result/rd bundle to the execute/memory boundary.

---
 rtl/ex_muldiv_if.sv | 27 ++
 rtl/ex_muldiv_unit.sv | 158 +++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_if.sv
// Request/response bundle between the decode/execute register, the
// hazard unit and the iterative RV32M multiply/divide unit.
interface ex_muldiv_if #(
    parameter int DATA_WIDTH = 32,
    parameter int WIDTH      = 5
);
    logic                  start;
    logic [2:0]            op;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [WIDTH-1:0]      rd_in;
    logic                  flush;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] result;
    logic [WIDTH-1:0]      rd_out;

    modport master (
        output start, op, a, b, rd_in, flush,
        input  busy, done, result, rd_out
    );

    modport slave (
        input  start, op, a, b, rd_in, flush,
        output busy, done, result, rd_out
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit (execute stage).
// Radix-2 shift-add multiply and restoring divide on operand magnitudes,
// followed by a two's-complement sign fix. Optional macro
// MULDIV_FASTMUL_EN replaces the iterative multiply with a single-cycle
// combinational multiply; divides stay iterative.
module ex_muldiv_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int WIDTH      = 5,
    parameter int CNT_W      = 6
) (
    input  logic         clk,
    input  logic         rst,
    ex_muldiv_if.slave   bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]            state;
    logic [2:0]            op_q;
    logic [WIDTH-1:0]      rd_q;
    logic [DATA_WIDTH-1:0] hi;      // product high word / partial remainder
    logic [DATA_WIDTH-1:0] lo;      // multiplier / dividend, becomes product low word / quotient
    logic [DATA_WIDTH-1:0] dvs;     // multiplicand or divisor magnitude
    logic                  neg;     // negate the selected result in FIX
    logic [CNT_W-1:0]      cnt;
    logic [DATA_WIDTH-1:0] result_q;
    logic [WIDTH-1:0]      rd_out_q;

    logic                    sgn_a_op, sgn_b_op, sa, sb;
    logic [DATA_WIDTH-1:0]   abs_a, abs_b;
    logic                    div_zero, ovf, special, neg_start;
    logic [DATA_WIDTH-1:0]   special_res;
    logic [DATA_WIDTH:0]     mul_sum, div_sh, div_diff;
    logic [2*DATA_WIDTH-1:0] prod_n;
    logic [DATA_WIDTH-1:0]   quo_n, rem_n, fix_res;

`ifdef MULDIV_FASTMUL_EN
    logic signed [DATA_WIDTH:0]     fa, fb;
    logic signed [2*DATA_WIDTH-1:0] fprod;
`endif

    assign bus.busy   = (state == S_CALC) || (state == S_FIX);
    assign bus.done   = (state == S_DONE);
    assign bus.result = result_q;
    assign bus.rd_out = rd_out_q;

    // Request decode: operand magnitudes, sign flags and single-cycle results
    always_comb begin
        sgn_a_op  = (bus.op == 3'b001) || (bus.op == 3'b010) || (bus.op[2] && !bus.op[0]);
        sgn_b_op  = (bus.op == 3'b001) || (bus.op[2] && !bus.op[0]);
        sa        = sgn_a_op && bus.a[DATA_WIDTH-1];
        sb        = sgn_b_op && bus.b[DATA_WIDTH-1];
        abs_a     = sa ? -bus.a : bus.a;
        abs_b     = sb ? -bus.b : bus.b;
        div_zero  = bus.op[2] && (bus.b == '0);
        ovf       = bus.op[2] && !bus.op[0] && (bus.a == {1'b1, {(DATA_WIDTH-1){1'b0}}})
                    && (bus.b == '1);
        // remainder follows the dividend; quotient/product follow the sign xor
        neg_start = (bus.op[2] && bus.op[1]) ? sa : (sa ^ sb);
        special   = div_zero || ovf;
        if (div_zero)
            special_res = bus.op[1] ? bus.a : '1;
        else
            special_res = bus.op[1] ? '0 : bus.a;
`ifdef MULDIV_FASTMUL_EN
        fa    = {sgn_a_op && bus.a[DATA_WIDTH-1], bus.a};
        fb    = {sgn_b_op && bus.b[DATA_WIDTH-1], bus.b};
        fprod = fa * fb;
        if (!bus.op[2]) begin
            special     = 1'b1;
            special_res = (bus.op == 3'b000) ? fprod[DATA_WIDTH-1:0]
                                             : fprod[2*DATA_WIDTH-1:DATA_WIDTH];
        end
`endif
    end

    // One radix-2 step for each algorithm plus the final sign fix/selection
    always_comb begin
        mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, dvs} : '0);
        div_sh   = {hi, lo[DATA_WIDTH-1]};
        div_diff = div_sh - {1'b0, dvs};
        prod_n   = neg ? -{hi, lo} : {hi, lo};
        quo_n    = neg ? -lo : lo;
        rem_n    = neg ? -hi : hi;
        if (op_q[2])
            fix_res = op_q[1] ? rem_n : quo_n;
        else if (op_q == 3'b000)
            fix_res = prod_n[DATA_WIDTH-1:0];
        else
            fix_res = prod_n[2*DATA_WIDTH-1:DATA_WIDTH];
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            op_q     <= '0;
            rd_q     <= '0;
            hi       <= '0;
            lo       <= '0;
            dvs      <= '0;
            neg      <= 1'b0;
            cnt      <= '0;
            result_q <= '0;
            rd_out_q <= '0;
        end else if (bus.flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        op_q <= bus.op;
                        rd_q <= bus.rd_in;
                        neg  <= neg_start;
                        cnt  <= '0;
                        if (special) begin
                            result_q <= special_res;
                            rd_out_q <= bus.rd_in;
                            state    <= S_DONE;
                        end else begin
                            hi    <= '0;
                            lo    <= abs_a;
                            dvs   <= abs_b;
                            state <= S_CALC;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_CALC: begin
                    cnt <= cnt + 1'b1;
                    if (op_q[2]) begin
                        if (!div_diff[DATA_WIDTH]) begin
                            hi <= div_diff[DATA_WIDTH-1:0];
                            lo <= {lo[DATA_WIDTH-2:0], 1'b1};
                        end else begin
                            hi <= div_sh[DATA_WIDTH-1:0];
                            lo <= {lo[DATA_WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        hi <= mul_sum[DATA_WIDTH:1];
                        lo <= {mul_sum[0], lo[DATA_WIDTH-1:1]};
                    end
                    if (cnt == CNT_W'(DATA_WIDTH-1))
                        state <= S_FIX;
                end
                S_FIX: begin
                    result_q <= fix_res;
                    rd_out_q <= rd_q;
                    state    <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: table of directed vectors plus
// hand-written flush, reset, ignored-start and back-to-back sequences.
module tb_ex_muldiv_unit;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    ex_muldiv_if #(.DATA_WIDTH(32), .WIDTH(5)) bus ();

    ex_muldiv_unit #(.DATA_WIDTH(32), .WIDTH(5), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        bit          special;
    } vec_t;

    vec_t vecs [0:21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [2:0] op, input bit special);
        if (special) return 1;
`ifdef MULDIV_FASTMUL_EN
        if (!op[2]) return 1;
`endif
        return 34;
    endfunction

    // Called at the first negedge after the accepting edge; that negedge is count 1.
    task automatic wait_done(output int lat, output int nbusy);
        lat   = 0;
        nbusy = 0;
        for (int k = 1; k <= 100; k++) begin
            if (bus.done) begin
                lat = k;
                break;
            end
            if (bus.busy) nbusy++;
            @(negedge clk);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.rd_in = rd;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        bus.rd_in = 5'($urandom);
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp, input bit special);
        int lat, nbusy, el;
        el = exp_lat(op, special);
        @(negedge clk);
        issue(op, a, b, rd);
        wait_done(lat, nbusy);
        check({name, " latency"}, 32'(lat), 32'(el));
        check({name, " result"}, bus.result, exp);
        check({name, " rd_out"}, {27'd0, bus.rd_out}, {27'd0, rd});
        check({name, " busy_cycles"}, 32'(nbusy), 32'(el - 1));
        @(negedge clk);
        check({name, " done_pulse"}, {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        int lat, nbusy, seen;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.op = 3'b000;
        bus.a = '0;
        bus.b = '0;
        bus.rd_in = '0;

        //         op      a             b             rd     expected      special
        vecs[0]  = '{3'b000, 32'd7,        32'hFFFFFFFD, 5'd1,  32'hFFFFFFEB, 1'b0};
        vecs[1]  = '{3'b001, 32'h80000000, 32'h80000000, 5'd2,  32'h40000000, 1'b0};
        vecs[2]  = '{3'b011, 32'h80000000, 32'h80000000, 5'd3,  32'h40000000, 1'b0};
        vecs[3]  = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'hFFFFFFFF, 1'b0};
        vecs[4]  = '{3'b100, 32'hFFFFFFEC, 32'd3,        5'd5,  32'hFFFFFFFA, 1'b0};
        vecs[5]  = '{3'b110, 32'hFFFFFFEC, 32'd3,        5'd6,  32'hFFFFFFFE, 1'b0};
        vecs[6]  = '{3'b101, 32'd100,      32'd7,        5'd7,  32'd14,       1'b0};
        vecs[7]  = '{3'b111, 32'd100,      32'd7,        5'd8,  32'd2,        1'b0};
        vecs[8]  = '{3'b101, 32'd5,        32'd0,        5'd9,  32'hFFFFFFFF, 1'b1};
        vecs[9]  = '{3'b110, 32'd5,        32'd0,        5'd10, 32'd5,        1'b1};
        vecs[10] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000, 1'b1};
        vecs[11] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'd0,        1'b1};
        vecs[12] = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd13, 32'hFFFFFFFE, 1'b0};
        vecs[13] = '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd14, 32'd1,        1'b0};
        vecs[14] = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd15, 32'd0,        1'b0};
        vecs[15] = '{3'b001, 32'd7,        32'hFFFFFFFD, 5'd16, 32'hFFFFFFFF, 1'b0};
        vecs[16] = '{3'b100, 32'd7,        32'hFFFFFFFE, 5'd17, 32'hFFFFFFFD, 1'b0};
        vecs[17] = '{3'b110, 32'd7,        32'hFFFFFFFE, 5'd18, 32'd1,        1'b0};
        vecs[18] = '{3'b100, 32'hFFFFFFF9, 32'd2,        5'd19, 32'hFFFFFFFD, 1'b0};
        vecs[19] = '{3'b110, 32'hFFFFFFF9, 32'd2,        5'd20, 32'hFFFFFFFF, 1'b0};
        vecs[20] = '{3'b111, 32'h80000000, 32'd3,        5'd21, 32'd2,        1'b0};
        vecs[21] = '{3'b111, 32'd5,        32'd0,        5'd22, 32'd5,        1'b1};

        repeat (3) @(negedge clk);
        check("reset busy", {31'd0, bus.busy}, 32'd0);
        check("reset done", {31'd0, bus.done}, 32'd0);
        check("reset result", bus.result, 32'd0);
        check("reset rd_out", {27'd0, bus.rd_out}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 22; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd,
                   vecs[i].exp, vecs[i].special);

        // Flush ten cycles into a divide: no done, then a fresh op completes.
        @(negedge clk);
        issue(3'b100, 32'd1000, 32'd7, 5'd4);
        repeat (9) @(negedge clk);
        check("flush busy_before", {31'd0, bus.busy}, 32'd1);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush busy_after", {31'd0, bus.busy}, 32'd0);
        check("flush done_after", {31'd0, bus.done}, 32'd0);
        seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen++;
        end
        check("flush idle_gap", 32'(seen), 32'd0);
        run_op("after_flush", 3'b101, 32'd100, 32'd7, 5'd23, 32'd14, 1'b0);

        // Reset in the middle of CALC clears everything and yields no done.
        @(negedge clk);
        issue(3'b100, 32'd100, 32'd7, 5'd5);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst busy", {31'd0, bus.busy}, 32'd0);
        check("midrst done", {31'd0, bus.done}, 32'd0);
        check("midrst result", bus.result, 32'd0);
        check("midrst rd_out", {27'd0, bus.rd_out}, 32'd0);
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen++;
        end
        check("midrst quiet", 32'(seen), 32'd0);

        // A start while busy is ignored; the original operation finishes.
        @(negedge clk);
        issue(3'b101, 32'd100, 32'd7, 5'd3);
        repeat (4) @(negedge clk);
        issue(3'b000, 32'd1, 32'd1, 5'd9);
        wait_done(lat, nbusy);
        check("ignored latency", 32'(lat + 5), 32'd34);
        check("ignored result", bus.result, 32'd14);
        check("ignored rd_out", {27'd0, bus.rd_out}, 32'd3);

        // Back-to-back: a start presented during DONE is accepted.
        @(negedge clk);
        issue(3'b101, 32'd100, 32'd7, 5'd3);
        wait_done(lat, nbusy);
        check("b2b first_result", bus.result, 32'd14);
        issue(3'b100, 32'hFFFFFFEC, 32'd3, 5'd6);
        check("b2b busy", {31'd0, bus.busy}, 32'd1);
        wait_done(lat, nbusy);
        check("b2b latency", 32'(lat), 32'd34);
        check("b2b result", bus.result, 32'hFFFFFFFA);
        check("b2b rd_out", {27'd0, bus.rd_out}, 32'd6);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
